// File: rtl/stack_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stack_mem_ctrl_pkg
// Shared definitions for the stack memory controller:
//   - state_t      : controller state encoding (IDLE=0, BUSY=1)
//   - DEF_*        : default data/address widths and RAM depth
//   - CNT_W        : width of the wait-state counter (waits are 0..15)
//   - wait_load()  : selects the wait-state preload for an access type
// -----------------------------------------------------------------------------
package stack_mem_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int CNT_W          = 4;

  // Extra BUSY cycles to spend before the access commits.
  function automatic logic [CNT_W-1:0] wait_load(input logic is_wr,
                                                 input int   rd_wait,
                                                 input int   wr_wait);
    return is_wr ? CNT_W'(wr_wait) : CNT_W'(rd_wait);
  endfunction

endpackage

// File: rtl/stack_mem_array.sv
// -----------------------------------------------------------------------------
// stack_mem_array
// Single-port RAM, 2**DEPTH_LOG2 x DATA_W, synchronous write and synchronous
// (registered) read. Contents are never reset. The read register only
// updates on i_re, so o_rdata holds the last word read between reads.
// Ports:
//   clk      in   rising-edge clock
//   i_we     in   write strobe
//   i_re     in   read strobe (loads the read register)
//   i_idx    in   word index
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module stack_mem_array
  import stack_mem_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_mem_ctrl.sv
// -----------------------------------------------------------------------------
// stack_mem_ctrl
// Memory controller sitting behind the ControlUnit. An access starts (in IDLE)
// on the first cycle after reset, on any address change, or when memory_w
// rises. The access runs for 1+RD_WAIT / 1+WR_WAIT cycles with memory_ready
// low, then commits against the internal RAM and raises memory_ready.
// Optional feature macro: STACK_MEM_ADDR_CHECK_EN
//   defined   : addresses >= 2**DEPTH_LOG2 run the normal wait sequence but a
//               write is dropped, a read returns 0, and mem_error is set
//               (sticky until reset)
//   undefined : upper address bits are ignored (index wraps), mem_error = 0
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   addr          in   word address from the CU
//   data_in       in   write data from the CU
//   memory_w      in   1 = write access, 0 = read access
//   data_out      out  read data, updated only when a read commits
//   memory_ready  out  1 = idle/complete, 0 = access in progress
//   mem_error     out  sticky out-of-range flag
// Assumes DEPTH_LOG2 <= ADDR_W and RD_WAIT/WR_WAIT in 0..15.
// -----------------------------------------------------------------------------
module stack_mem_ctrl
  import stack_mem_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int RD_WAIT    = 0,
  parameter int WR_WAIT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              memory_w,
  output logic [DATA_W-1:0] data_out,
  output logic              memory_ready,
  output logic              mem_error
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_ready;
  logic               w_ready_next;

  // Latched copy of the access in flight; also the reference for retriggering.
  logic [ADDR_W-1:0]  r_last_addr;
  logic               r_last_w;
  logic               r_last_vld;
  logic [DATA_W-1:0]  r_wdata;

  // Forces data_out to zero after reset and after a blocked read.
  logic               r_dout_zero;

  logic               w_start_cond;
  logic               w_start;
  logic               w_commit;
  logic               w_rd_commit;
  logic               w_blocked;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [DATA_W-1:0]  w_ram_q;

  // Holding memory_w high on the same address must not retrigger a write.
  assign w_start_cond = !r_last_vld || (addr != r_last_addr) || (memory_w && !r_last_w);

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ready_next = r_ready;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_cond) begin
          w_start      = 1'b1;
          w_state_next = ST_BUSY;
          w_ready_next = 1'b0;
          w_cnt_next   = wait_load(memory_w, RD_WAIT, WR_WAIT);
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_commit     = 1'b1;
          w_ready_next = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_last_addr <= '0;
      r_last_w    <= 1'b0;
      r_last_vld  <= 1'b0;
      r_wdata     <= '0;
      r_dout_zero <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ready <= w_ready_next;
      if (w_start) begin
        r_last_addr <= addr;
        r_last_w    <= memory_w;
        r_last_vld  <= 1'b1;
        r_wdata     <= data_in;
      end
      if (w_rd_commit) begin
        r_dout_zero <= w_blocked;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional out-of-range check
  // ---------------------------------------------------------------------------
`ifdef STACK_MEM_ADDR_CHECK_EN
  logic r_oor;
  logic r_err;
  logic w_addr_oor;

  assign w_addr_oor = (addr >> DEPTH_LOG2) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oor <= 1'b0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_oor <= w_addr_oor;
      if (w_addr_oor) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_blocked = r_oor;
  assign mem_error = r_err;
`else
  assign w_blocked = 1'b0;
  assign mem_error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  assign w_rd_commit = w_commit && !r_last_w;
  assign w_ram_we    = w_commit && r_last_w && !w_blocked;
  assign w_ram_re    = w_rd_commit && !w_blocked;

  stack_mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_idx   (r_last_addr[DEPTH_LOG2-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  // The RAM read register only moves on a good read, so this holds the last
  // read value across writes.
  assign data_out     = r_dout_zero ? '0 : w_ram_q;
  assign memory_ready = r_ready;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_mem_ctrl
// Randomized scoreboard bench for stack_mem_ctrl (DEPTH_LOG2=4, RD_WAIT=3,
// WR_WAIT=1). The driver pushes the expected result of each access into a
// queue; an independent monitor pops an entry whenever memory_ready falls
// and checks latency, data_out hold/update and mem_error.
// -----------------------------------------------------------------------------
module tb_stack_mem_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int DL      = 4;
  localparam int DEPTH   = 1 << DL;
  localparam int RD_WAIT = 3;
  localparam int WR_WAIT = 1;
`ifdef STACK_MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              memory_w = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              memory_ready;
  logic              mem_error;

  always #5 clk = ~clk;

  stack_mem_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH_LOG2 (DL),
    .RD_WAIT    (RD_WAIT),
    .WR_WAIT    (WR_WAIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .data_in      (data_in),
    .memory_w     (memory_w),
    .data_out     (data_out),
    .memory_ready (memory_ready),
    .mem_error    (mem_error)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_wr;
    int          lat;
    bit          prev_known;
    logic [15:0] prev;
    bit          new_known;
    logic [15:0] dout;
    bit          err;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [15:0] m_ram [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_dout = '0;
  bit          m_dout_known = 1'b1;
  bit          m_err = 1'b0;
  logic [15:0] m_last_addr = '0;
  bit          m_last_w = 1'b0;
  bit          m_last_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Poll memory_ready just after rising edges; an expired budget is a failure.
  task automatic wait_idle();
    for (int i = 0; i < 64 && memory_ready !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check("idle_timeout", memory_ready, 1'b1);
  endtask

  // Issue one access. overlap=1 applies the new inputs while the previous
  // access is still BUSY, so it must start on the first IDLE edge.
  task automatic issue(input bit is_wr, input logic [15:0] a_in, input logic [15:0] d, input bit overlap);
    logic [15:0] a;
    exp_t        e;
    int          idx;
    bit          blocked;
    bit          ov;
    a  = a_in;
    ov = overlap;
    // A read only starts on a new address.
    if (!is_wr && m_last_vld && a == m_last_addr) a = a ^ 16'd1;
    // A repeated write to the same address needs memory_w low for an idle cycle.
    if (is_wr && m_last_vld && a == m_last_addr && m_last_w) begin
      wait_idle();
      memory_w = 1'b0;
      @(posedge clk);
      #1;
      ov = 1'b0;
    end
    idx     = int'(a) % DEPTH;
    blocked = CHK && (int'(a) >= DEPTH);
    e.is_wr      = is_wr;
    e.lat        = (is_wr ? WR_WAIT : RD_WAIT) + 1;
    e.prev       = m_dout;
    e.prev_known = m_dout_known;
    if (blocked) m_err = 1'b1;
    if (is_wr) begin
      if (!blocked) begin
        m_ram[idx]   = d;
        m_known[idx] = 1'b1;
      end
    end else begin
      if (blocked) begin
        m_dout       = '0;
        m_dout_known = 1'b1;
      end else begin
        m_dout       = m_ram[idx];
        m_dout_known = m_known[idx];
      end
    end
    e.dout      = m_dout;
    e.new_known = m_dout_known;
    e.err       = m_err;
    m_last_addr = a;
    m_last_w    = is_wr;
    m_last_vld  = 1'b1;
    sb_q.push_back(e);

    if (!ov) wait_idle();
    addr     = a;
    data_in  = d;
    memory_w = is_wr;
    wait_idle();
    @(posedge clk);
    #1;
    check("start_edge", memory_ready, 1'b0);
    $display("TXN %s addr=%04h data=%04h overlap=%0d", is_wr ? "WR" : "RD", a, d, ov);
  endtask

  // Monitor: one scoreboard entry per low pulse of memory_ready.
  initial begin
    exp_t cur;
    int   low = 0;
    bit   busy = 1'b0;
    bit   ghost = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy  = 1'b0;
        ghost = 1'b0;
      end else if (!busy) begin
        if (memory_ready === 1'b0) begin
          busy = 1'b1;
          low  = 1;
          if (sb_q.size() == 0) begin
            ghost = 1'b1;
            checks++;
            errors++;
            $display("FAIL spurious_start: got ready=0 expected ready=1 (no access pending, t=%0t)", $time);
          end else begin
            ghost = 1'b0;
            cur   = sb_q.pop_front();
            if (cur.prev_known) check("dout_hold", data_out, cur.prev);
          end
        end
      end else if (memory_ready === 1'b0) begin
        low++;
        if (!ghost && cur.prev_known) check("dout_hold", data_out, cur.prev);
      end else begin
        busy = 1'b0;
        if (!ghost) begin
          check(cur.is_wr ? "wr_latency" : "rd_latency", low, cur.lat);
          if (cur.new_known) check(cur.is_wr ? "dout_after_wr" : "rd_data", data_out, cur.dout);
          check("mem_error", mem_error, cur.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", memory_ready, 1'b1);
    check("rst_dout", data_out, 16'h0);
    check("rst_err", mem_error, 1'b0);
    rst_n = 1'b1;

    // First access after reset starts with unchanged inputs (addr=0, read).
    issue(1'b0, 16'h0000, 16'h0, 1'b0);

    // Fill the RAM so every later read has a known expectation.
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b1, 16'(i), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Write 0xBEEF then read it back; then address changes during BUSY.
    issue(1'b1, 16'h0005, 16'hBEEF, 1'b0);
    issue(1'b0, 16'h0005, 16'h0000, 1'b0);
    issue(1'b0, 16'h0006, 16'h0000, 1'b0);
    issue(1'b0, 16'h0005, 16'h0000, 1'b0);
    issue(1'b0, 16'h0006, 16'h1234, 1'b1);
    issue(1'b0, 16'h0009, 16'h0000, 1'b0);

    // Randomized traffic, including upper address bits and overlapped issue.
    for (int t = 0; t < 200; t++) begin
      a = 16'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) a[15:DL] = 12'($urandom_range(1, 4095));
      issue(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 2) == 0);
    end

    // Reset in the middle of a write to addr 7: the write must be lost.
    issue(1'b0, 16'h0003, 16'h0000, 1'b0);
    wait_idle();
    addr     = 16'h0007;
    data_in  = ~m_ram[7];
    memory_w = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", memory_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", memory_ready, 1'b1);
    check("rst_mid_dout", data_out, 16'h0);
    check("rst_mid_err", mem_error, 1'b0);
    memory_w     = 1'b0;
    m_dout       = '0;
    m_dout_known = 1'b1;
    m_err        = 1'b0;
    m_last_vld   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Same address as before reset, but last_vld was cleared: read restarts.
    issue(1'b0, 16'h0007, 16'h0000, 1'b0);

    // Quiet period: held inputs must not retrigger.
    wait_idle();
    repeat (6) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
